// File: rtl/svarog2_lsu_if.sv
// Bus bundles for the Svarog2 load/store unit.
// svarog2_lsu_req_if : core <-> LSU request/response channel (master = core, slave = LSU)
// svarog2_lsu_mem_if : LSU <-> data memory channel (master = LSU, slave = memory)
// Signal names keep their _i/_o suffixes as seen from the LSU so they map 1:1 to the port list.

interface svarog2_lsu_req_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid_i;
    logic                  req_ready_o;
    logic                  req_we_i;
    logic [1:0]            req_size_i;
    logic                  req_unsigned_i;
    logic [ADDR_WIDTH-1:0] req_addr_i;
    logic [DATA_WIDTH-1:0] req_wdata_i;
    logic                  rsp_valid_o;
    logic [DATA_WIDTH-1:0] rsp_rdata_o;
    logic                  rsp_err_o;
    logic [1:0]            rsp_err_code_o;
    logic                  busy_o;

    modport master (
        output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_err_code_o, busy_o
    );

    modport slave (
        input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_err_code_o, busy_o
    );
endinterface

interface svarog2_lsu_mem_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    localparam int LANES = DATA_WIDTH / 8;

    logic                  mem_req_o;
    logic                  mem_we_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [LANES-1:0]      mem_be_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o;
    logic                  mem_ack_i;
    logic [DATA_WIDTH-1:0] mem_rdata_i;

    modport master (
        output mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
        input  mem_ack_i, mem_rdata_i
    );

    modport slave (
        input  mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
        output mem_ack_i, mem_rdata_i
    );
endinterface

// File: rtl/svarog2_lsu.sv
// Svarog2 load/store unit: sub-word loads/stores with byte enables, misalignment
// and illegal-size detection, and a valid/ack memory handshake with timeout.
// Three-state flow IDLE -> ACCESS -> RESP; error requests skip ACCESS entirely.

module svarog2_lsu #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk_i,
    input  logic              reset_i,
    svarog2_lsu_req_if.slave  core,
    svarog2_lsu_mem_if.master mem
);

    localparam int LANES   = DATA_WIDTH / 8;
    localparam int LW      = $clog2(LANES);
    localparam int CW      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    // Counter value in the last ACCESS cycle before giving up.
    localparam int TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  we_q, we_d;
    logic [1:0]            size_q, size_d;
    logic                  uns_q, uns_d;
    logic [LW-1:0]         lane_q, lane_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LANES-1:0]      be_q, be_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  mem_req_q, mem_req_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [1:0]            rsp_code_q, rsp_code_d;

    logic [DATA_WIDTH-1:0] wdata_rep;
    logic [LANES-1:0]      be_base;
    logic [LANES-1:0]      be_calc;
    logic                  misaligned;
    logic                  illegal_size;
    logic                  timeout_hit;
    logic [DATA_WIDTH-1:0] rdata_shifted;
    logic [DATA_WIDTH-1:0] ext_mask;
    logic                  sign_bit;
    logic [DATA_WIDTH-1:0] load_data;

    // Store data replication: each lane takes the byte of the right-aligned
    // operand that lands on it for the requested access size.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_rep
            assign wdata_rep[8*gi +: 8] =
                (core.req_size_i == 2'd0) ? core.req_wdata_i[7:0] :
                (core.req_size_i == 2'd1) ? core.req_wdata_i[8*(gi % 2) +: 8] :
                (core.req_size_i == 2'd2) ? core.req_wdata_i[8*(gi % 4) +: 8] :
                                            core.req_wdata_i[8*gi +: 8];
        end
    endgenerate

    // Request decode: byte-enable pattern and alignment/size legality.
    always_comb begin
        be_base      = '0;
        misaligned   = 1'b0;
        case (core.req_size_i)
            2'd0: begin be_base = LANES'(1);   misaligned = 1'b0; end
            2'd1: begin be_base = LANES'(3);   misaligned = core.req_addr_i[0]; end
            2'd2: begin be_base = LANES'(15);  misaligned = |core.req_addr_i[1:0]; end
            default: begin be_base = LANES'(255); misaligned = |core.req_addr_i[2:0]; end
        endcase
        be_calc      = be_base << core.req_addr_i[LW-1:0];
        illegal_size = (core.req_size_i == 2'd3) && (DATA_WIDTH == 32);
    end

    // Load data alignment and sign/zero extension from the latched size and lane.
    always_comb begin
        rdata_shifted = mem.mem_rdata_i >> {lane_q, 3'b000};
        ext_mask      = '1;
        sign_bit      = 1'b0;
        case (size_q)
            2'd0: begin ext_mask = DATA_WIDTH'(8'hFF);         sign_bit = rdata_shifted[7];  end
            2'd1: begin ext_mask = DATA_WIDTH'(16'hFFFF);      sign_bit = rdata_shifted[15]; end
            2'd2: begin ext_mask = DATA_WIDTH'(32'hFFFF_FFFF); sign_bit = rdata_shifted[31]; end
            default: begin ext_mask = '1;                      sign_bit = 1'b0;              end
        endcase
        load_data = (rdata_shifted & ext_mask) |
                    ((!uns_q && sign_bit) ? ~ext_mask : '0);
    end

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST[CW-1:0]);

    // Next-state and next-output computation for the access FSM.
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        size_d      = size_q;
        uns_d       = uns_q;
        lane_d      = lane_q;
        addr_d      = addr_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        mem_req_d   = mem_req_q;
        cnt_d       = cnt_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        rsp_code_d  = rsp_code_q;

        case (state_q)
            IDLE: begin
                if (core.req_valid_i) begin
                    we_d    = core.req_we_i;
                    size_d  = core.req_size_i;
                    uns_d   = core.req_unsigned_i;
                    lane_d  = core.req_addr_i[LW-1:0];
                    addr_d  = {core.req_addr_i[ADDR_WIDTH-1:LW], {LW{1'b0}}};
                    be_d    = be_calc;
                    wdata_d = wdata_rep;
                    cnt_d   = '0;
                    if (illegal_size || misaligned) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = '0;
                        rsp_err_d   = 1'b1;
                        rsp_code_d  = illegal_size ? 2'd2 : 2'd1;
                    end else begin
                        state_d   = ACCESS;
                        mem_req_d = 1'b1;
                    end
                end
            end
            ACCESS: begin
                // Ack takes priority over a timeout landing in the same cycle.
                if (mem.mem_ack_i) begin
                    state_d     = RESP;
                    mem_req_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = we_q ? '0 : load_data;
                    rsp_err_d   = 1'b0;
                    rsp_code_d  = 2'd0;
                end else if (timeout_hit) begin
                    state_d     = RESP;
                    mem_req_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    rsp_code_d  = 2'd3;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset clears everything and drops mem_req at once.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            size_q      <= 2'd0;
            uns_q       <= 1'b0;
            lane_q      <= '0;
            addr_q      <= '0;
            be_q        <= '0;
            wdata_q     <= '0;
            mem_req_q   <= 1'b0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_code_q  <= 2'd0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            lane_q      <= lane_d;
            addr_q      <= addr_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            mem_req_q   <= mem_req_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            rsp_code_q  <= rsp_code_d;
        end
    end

    assign core.req_ready_o    = (state_q == IDLE);
    assign core.busy_o         = (state_q != IDLE);
    assign core.rsp_valid_o    = rsp_valid_q;
    assign core.rsp_rdata_o    = rsp_rdata_q;
    assign core.rsp_err_o      = rsp_err_q;
    assign core.rsp_err_code_o = rsp_code_q;

    assign mem.mem_req_o   = mem_req_q;
    assign mem.mem_we_o    = we_q;
    assign mem.mem_addr_o  = addr_q;
    assign mem.mem_be_o    = be_q;
    assign mem.mem_wdata_o = wdata_q;

endmodule
